// File: rtl/sb_slot_decode_ctrl_pkg.sv
// Shared types for the store-buffer slot controller: slot index/mask widths,
// drain FSM states and a popcount helper for the valid bitmap.
package sb_pkg;

  localparam int SB_ENTRIES = 8;
  localparam int SB_IDX_W   = $clog2(SB_ENTRIES);

  typedef logic [SB_IDX_W-1:0]   sb_idx_t;
  typedef logic [SB_ENTRIES-1:0] sb_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK
  } drain_state_e;

  // Result is 4 bits wide so a completely full buffer (8) is representable.
  function automatic logic [3:0] popcount8(input sb_mask_t mask);
    logic [3:0] total;
    total = 4'd0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      total = total + {3'd0, mask[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/sb_slot_decode_ctrl_onehot.sv
// Combinational 3-to-8 decoder with enable; the output is all zeros when not
// enabled, so at most one bit is ever set.
module binary_to_onehot_8bit
  import sb_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  assign onehot = en ? (sb_mask_t'(1) << idx) : sb_mask_t'(0);

endmodule

// File: rtl/sb_slot_decode_ctrl.sv
// Store-buffer slot controller: owns the per-slot valid bitmap, decodes
// allocation/clear indices to one-hot pulses and drains one slot at a time.
module sb_slot_decode_ctrl
  import sb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [2:0] wr_idx,
  output logic       wr_ready,
  output logic [7:0] wr_en_onehot,
  input  logic       drain_en,
  input  logic [2:0] drain_idx,
  output logic       mem_req,
  output logic [2:0] mem_idx,
  input  logic       mem_gnt,
  input  logic       mem_ack,
  output logic [7:0] clr_onehot,
  output logic [7:0] valid_mask,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       err_dup,
  output logic       err_drain
);

  drain_state_e state_q, state_d;

  sb_idx_t    memIdx_q, memIdx_d;
  sb_mask_t   validMask_q, validMask_d;
  logic [3:0] count_q, count_d;
  logic       full_q, full_d;
  logic       empty_q, empty_d;
  sb_mask_t   wrEn_q, clr_q;
  logic       errDup_q, errDrain_q;

  logic     allocAccept;
  logic     allocEn;
  logic     dupHit;
  logic     captureEn;
  logic     drainHitsInvalid;
  logic     ackClear;
  logic     memReq;
  sb_mask_t allocOnehot;
  sb_mask_t clrOnehot;

  // A slot being drained is still valid, so re-allocating it is a dup error.
  assign allocAccept = wr_valid && !full_q;
  assign dupHit      = allocAccept && validMask_q[wr_idx];
  assign allocEn     = allocAccept && !validMask_q[wr_idx];

  binary_to_onehot_8bit uAllocDec (
    .idx    (wr_idx),
    .en     (allocEn),
    .onehot (allocOnehot)
  );

  binary_to_onehot_8bit uClrDec (
    .idx    (memIdx_q),
    .en     (ackClear),
    .onehot (clrOnehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (drain_en && !empty_q && validMask_q[drain_idx]) state_d = REQ;
      REQ:      if (mem_gnt) state_d = WAIT_ACK;
      WAIT_ACK: if (mem_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    memReq    = 1'b0;
    captureEn = 1'b0;
    ackClear  = 1'b0;
    unique case (state_q)
      IDLE:     captureEn = drain_en && !empty_q;
      REQ:      memReq    = 1'b1;
      WAIT_ACK: ackClear  = mem_ack;
      default:  begin end
    endcase
  end

  assign drainHitsInvalid = captureEn && !validMask_q[drain_idx];

  // Set and clear can never target the same slot, so their order is irrelevant.
  always_comb begin
    validMask_d = (validMask_q | allocOnehot) & ~clrOnehot;
    count_d     = popcount8(validMask_d);
    full_d      = (count_d == 4'd8);
    empty_d     = (count_d == 4'd0);
    memIdx_d    = captureEn ? drain_idx : memIdx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memIdx_q    <= '0;
      validMask_q <= '0;
      count_q     <= 4'd0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      wrEn_q      <= '0;
      clr_q       <= '0;
      errDup_q    <= 1'b0;
      errDrain_q  <= 1'b0;
    end else begin
      memIdx_q    <= memIdx_d;
      validMask_q <= validMask_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      wrEn_q      <= allocOnehot;
      clr_q       <= clrOnehot;
      errDup_q    <= errDup_q || dupHit;
      errDrain_q  <= errDrain_q || drainHitsInvalid;
    end
  end

  assign wr_ready     = !full_q;
  assign wr_en_onehot = wrEn_q;
  assign mem_req      = memReq;
  assign mem_idx      = memIdx_q;
  assign clr_onehot   = clr_q;
  assign valid_mask   = validMask_q;
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign err_dup      = errDup_q;
  assign err_drain    = errDrain_q;

endmodule

// File: tb/tb_sb_slot_decode_ctrl.sv
// Scenario bench for sb_slot_decode_ctrl: a small bitmap model predicts the
// write/clear pulses, which are queued when driven and compared when they appear.
module tb_sb_slot_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_idx = 3'd0;
  logic       wr_ready;
  logic [7:0] wr_en_onehot;
  logic       drain_en = 1'b0;
  logic [2:0] drain_idx = 3'd0;
  logic       mem_req;
  logic [2:0] mem_idx;
  logic       mem_gnt = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] clr_onehot;
  logic [7:0] valid_mask;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       err_dup;
  logic       err_drain;

  int checks = 0;
  int errors = 0;

  logic [7:0] mMask;
  logic       mDup;
  logic [7:0] expWrQ[$];
  logic [7:0] expClrQ[$];
  logic [7:0] expV;
  int         reqHigh;

  sb_slot_decode_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_idx       (wr_idx),
    .wr_ready     (wr_ready),
    .wr_en_onehot (wr_en_onehot),
    .drain_en     (drain_en),
    .drain_idx    (drain_idx),
    .mem_req      (mem_req),
    .mem_idx      (mem_idx),
    .mem_gnt      (mem_gnt),
    .mem_ack      (mem_ack),
    .clr_onehot   (clr_onehot),
    .valid_mask   (valid_mask),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .err_dup      (err_dup),
    .err_drain    (err_drain)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    wr_valid = 1'b0;
    drain_en = 1'b0;
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    mMask = 8'h00;
    mDup = 1'b0;
    expWrQ.delete();
    expClrQ.delete();
  endtask

  // Drives one allocation for one edge and queues the pulse the model predicts.
  task automatic driveAlloc(input logic [2:0] idx);
    logic [7:0] pulse;
    pulse = 8'h00;
    if (mMask != 8'hFF) begin
      if (!mMask[idx]) pulse = 8'h01 << idx;
      else mDup = 1'b1;
    end
    expWrQ.push_back(pulse);
    wr_valid = 1'b1;
    wr_idx = idx;
    tick();
    wr_valid = 1'b0;
    mMask = mMask | pulse;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if (valid_mask !== 8'h00 || count !== 4'd0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got mask=%h count=%0d full=%b required 00/0/0", valid_mask, count, full);
    end
    checks++;
    if (empty !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got empty=%b wr_ready=%b required 1/1", empty, wr_ready);
    end
    checks++;
    if (mem_req !== 1'b0 || wr_en_onehot !== 8'h00 || clr_onehot !== 8'h00 || err_dup !== 1'b0 || err_drain !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req=%b wr=%h clr=%h dup=%b derr=%b required all 0",
               mem_req, wr_en_onehot, clr_onehot, err_dup, err_drain);
    end
  endtask

  task automatic test_alloc_basic();
    logic [2:0] seq [3];
    seq = '{3'd3, 3'd5, 3'd0};
    doReset();
    for (int i = 0; i < 3; i++) begin
      driveAlloc(seq[i]);
      expV = expWrQ.pop_front();
      checks++;
      if (wr_en_onehot !== expV) begin
        errors++;
        $display("[TB] FAIL alloc_pulse[%0d]: got %h required %h", i, wr_en_onehot, expV);
      end
    end
    checks++;
    if (valid_mask !== 8'h29 || count !== 4'd3 || empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alloc_mask: got mask=%h count=%0d empty=%b required 29/3/0", valid_mask, count, empty);
    end
    tick();
    checks++;
    if (wr_en_onehot !== 8'h00) begin
      errors++;
      $display("[TB] FAIL alloc_pulse_width: got %h required 00", wr_en_onehot);
    end
  endtask

  task automatic test_full();
    logic [2:0] rest [5];
    rest = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7};
    for (int i = 0; i < 5; i++) begin
      driveAlloc(rest[i]);
      expV = expWrQ.pop_front();
      checks++;
      if (wr_en_onehot !== expV || valid_mask !== mMask || count !== 4'($countones(mMask))) begin
        errors++;
        $display("[TB] FAIL fill[%0d]: got wr=%h mask=%h count=%0d required %h/%h/%0d",
                 i, wr_en_onehot, valid_mask, count, expV, mMask, $countones(mMask));
      end
    end
    checks++;
    if (full !== 1'b1 || wr_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL full_flags: got full=%b ready=%b count=%0d required 1/0/8", full, wr_ready, count);
    end
    driveAlloc(3'd2);
    expV = expWrQ.pop_front();
    checks++;
    if (wr_en_onehot !== expV || err_dup !== mDup) begin
      errors++;
      $display("[TB] FAIL alloc_when_full: got wr=%h dup=%b required %h/%b", wr_en_onehot, err_dup, expV, mDup);
    end
  endtask

  task automatic test_drain();
    doReset();
    driveAlloc(3'd5);
    void'(expWrQ.pop_front());
    reqHigh = 0;
    drain_en = 1'b1;
    drain_idx = 3'd5;
    tick();
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (mem_req === 1'b1) reqHigh++;
      checks++;
      if (mem_req !== 1'b1 || mem_idx !== 3'd5) begin
        errors++;
        $display("[TB] FAIL drain_req[%0d]: got req=%b idx=%0d required 1/5", k, mem_req, mem_idx);
      end
      mem_gnt = (k == 2);
      tick();
    end
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (mem_req === 1'b1) reqHigh++;
      tick();
    end
    if (mem_req === 1'b1) reqHigh++;
    mem_ack = 1'b1;
    expClrQ.push_back(8'h20);
    tick();
    mem_ack = 1'b0;
    mMask[5] = 1'b0;
    expV = expClrQ.pop_front();
    checks++;
    if (reqHigh != 3) begin
      errors++;
      $display("[TB] FAIL drain_req_len: got %0d cycles required 3", reqHigh);
    end
    checks++;
    if (clr_onehot !== expV || empty !== 1'b1 || valid_mask !== mMask) begin
      errors++;
      $display("[TB] FAIL drain_clear: got clr=%h empty=%b mask=%h required %h/1/%h", clr_onehot, empty, valid_mask, expV, mMask);
    end
    tick();
    checks++;
    if (clr_onehot !== 8'h00 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_idle: got clr=%h req=%b required 00/0", clr_onehot, mem_req);
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    driveAlloc(3'd5);
    void'(expWrQ.pop_front());
    drain_en = 1'b1;
    drain_idx = 3'd5;
    tick();
    drain_en = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    driveAlloc(3'd5);
    expV = expWrQ.pop_front();
    checks++;
    if (wr_en_onehot !== expV || err_dup !== 1'b1 || valid_mask !== 8'h20) begin
      errors++;
      $display("[TB] FAIL dup_on_drain: got wr=%h dup=%b mask=%h required %h/1/20", wr_en_onehot, err_dup, valid_mask, expV);
    end
    mem_ack = 1'b1;
    expClrQ.push_back(8'h20);
    driveAlloc(3'd1);
    mem_ack = 1'b0;
    mMask[5] = 1'b0;
    expV = expWrQ.pop_front();
    checks++;
    if (wr_en_onehot !== expV || clr_onehot !== expClrQ.pop_front()) begin
      errors++;
      $display("[TB] FAIL alloc_and_clear_pulses: got wr=%h clr=%h required %h/20", wr_en_onehot, clr_onehot, expV);
    end
    checks++;
    if (valid_mask !== mMask || count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL alloc_and_clear_mask: got mask=%h count=%0d required %h/1", valid_mask, count, mMask);
    end
  endtask

  task automatic test_drain_err();
    doReset();
    driveAlloc(3'd0);
    void'(expWrQ.pop_front());
    drain_en = 1'b1;
    drain_idx = 3'd4;
    tick();
    drain_en = 1'b0;
    checks++;
    if (err_drain !== 1'b1 || mem_req !== 1'b0 || mem_idx !== 3'd4) begin
      errors++;
      $display("[TB] FAIL drain_invalid: got derr=%b req=%b idx=%0d required 1/0/4", err_drain, mem_req, mem_idx);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0 || valid_mask !== 8'h01) begin
      errors++;
      $display("[TB] FAIL drain_invalid_idle: got req=%b mask=%h required 0/01", mem_req, valid_mask);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] clrSeen;
    doReset();
    driveAlloc(3'd0);
    drain_en = 1'b1;
    drain_idx = 3'd4;
    tick();
    drain_en = 1'b0;
    for (int i = 1; i < 8; i++) driveAlloc(3'(i));
    checks++;
    if (valid_mask !== 8'hFF || err_drain !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prefill: got mask=%h derr=%b required FF/1", valid_mask, err_drain);
    end
    drain_en = 1'b1;
    drain_idx = 3'd2;
    tick();
    drain_en = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_before_reset: got %b required 1", mem_req);
    end
    rst = 1'b1;
    mem_ack = 1'b1;
    tick();
    clrSeen = clr_onehot;
    rst = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || valid_mask !== 8'h00 || empty !== 1'b1 || clrSeen !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain: got req=%b mask=%h empty=%b clr=%h required 0/00/1/00",
               mem_req, valid_mask, empty, clrSeen);
    end
    checks++;
    if (err_dup !== 1'b0 || err_drain !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_flags: got dup=%b derr=%b count=%0d required 0/0/0", err_dup, err_drain, count);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_full();
    test_drain();
    test_simultaneous();
    test_drain_err();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
